// File: rtl/backprop_pkg.sv
// Shared types and constants for the backprop issue-side sequencer.
package backprop_pkg;

  localparam int BP_INDEX_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COST     = 2'd1,
    BACKPROP = 2'd2,
    DONE     = 2'd3
  } bp_state_t;

endpackage

// File: rtl/backprop_position_counter.sv
// Nested (layer, row) position counter: row counts up and wraps, layer counts
// down on the row wrap. Load restarts at (LAYERS-1, 0).
module backprop_position_counter
  import backprop_pkg::*;
#(
  parameter int ROWS   = 3,
  parameter int LAYERS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic                  i_advance,
  output logic [BP_INDEX_W-1:0] o_layer,
  output logic [BP_INDEX_W-1:0] o_row,
  output logic                  o_row_last,
  output logic                  o_last
);

  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int LAYER_W = (LAYERS > 1) ? $clog2(LAYERS) : 1;
  localparam logic [ROW_W-1:0]   ROW_MAX   = ROW_W'(ROWS - 1);
  localparam logic [LAYER_W-1:0] LAYER_TOP = LAYER_W'(LAYERS - 1);

  logic [ROW_W-1:0]   r_row;
  logic [LAYER_W-1:0] r_layer;
  logic               w_row_last;

  assign w_row_last = (r_row == ROW_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row   <= '0;
      r_layer <= '0;
    end else if (i_load) begin
      r_row   <= '0;
      r_layer <= LAYER_TOP;
    end else if (i_advance) begin
      if (w_row_last) begin
        r_row   <= '0;
        r_layer <= r_layer - LAYER_W'(1);
      end else begin
        r_row <= r_row + ROW_W'(1);
      end
    end
  end

  assign o_layer    = BP_INDEX_W'(r_layer);
  assign o_row      = BP_INDEX_W'(r_row);
  assign o_row_last = w_row_last;
  assign o_last     = w_row_last && (r_layer == '0);

endmodule

// File: rtl/backprop_sequencer.sv
// Issue-side controller for the backprop pipeline: captures the error vector on
// start, then emits cost beats followed by weight-update beats, last layer first.
//
// state    | meaning
// IDLE     | waiting for start
// COST     | issuing cost-layer beats (layer_count-1, 0..size-1)
// BACKPROP | issuing update beats, layer counting down to 0
// DONE     | first cycle raises done, second cycle returns to IDLE
module backprop_sequencer
  import backprop_pkg::*;
#(
  parameter int SIZE        = 3,
  parameter int DATA_SIZE   = 16,
  parameter int LAYER_COUNT = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      hold,
  input  logic                      abort,
  input  logic [SIZE*DATA_SIZE-1:0] diff_in,
  output logic [BP_INDEX_W-1:0]     w_layer_index,
  output logic [BP_INDEX_W-1:0]     w_row_index,
  output logic                      backprop_cost,
  output logic                      is_cost_layer,
  output logic                      is_update,
  output logic [SIZE*DATA_SIZE-1:0] diff_start,
  output logic                      busy,
  output logic                      done
);

  bp_state_t                 r_state;
  bp_state_t                 w_next_state;
  logic [BP_INDEX_W-1:0]     r_layer_index;
  logic [BP_INDEX_W-1:0]     r_row_index;
  logic                      r_cost;
  logic                      r_update;
  logic                      r_done;
  logic [SIZE*DATA_SIZE-1:0] r_diff_start;

  logic                  w_accept;
  logic                  w_beat;
  logic                  w_cost_beat;
  logic                  w_update_beat;
  logic                  w_load;
  logic [BP_INDEX_W-1:0] w_pos_layer;
  logic [BP_INDEX_W-1:0] w_pos_row;
  logic                  w_pos_row_last;
  logic                  w_pos_last;

  backprop_position_counter #(
    .ROWS   (SIZE),
    .LAYERS (LAYER_COUNT)
  ) u_pos (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_advance  (w_beat),
    .o_layer    (w_pos_layer),
    .o_row      (w_pos_row),
    .o_row_last (w_pos_row_last),
    .o_last     (w_pos_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (abort) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:     if (start) w_next_state = COST;
        COST:     if (!hold && w_pos_row_last) w_next_state = BACKPROP;
        BACKPROP: if (!hold && w_pos_last) w_next_state = DONE;
        DONE:     if (r_done) w_next_state = IDLE;
        default:  w_next_state = IDLE;
      endcase
    end
  end

  // The cost-to-update transition reloads the counter instead of wrapping it.
  always_comb begin
    w_accept      = (r_state == IDLE) && start;
    w_cost_beat   = (r_state == COST) && !hold;
    w_update_beat = (r_state == BACKPROP) && !hold;
    w_beat        = w_cost_beat || w_update_beat;
    w_load        = w_accept || (w_cost_beat && w_pos_row_last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_layer_index <= '0;
      r_row_index   <= '0;
      r_cost        <= 1'b0;
      r_update      <= 1'b0;
      r_done        <= 1'b0;
      r_diff_start  <= '0;
    end else if (abort) begin
      r_layer_index <= '0;
      r_row_index   <= '0;
      r_cost        <= 1'b0;
      r_update      <= 1'b0;
      r_done        <= 1'b0;
      r_diff_start  <= '0;
    end else begin
      r_cost   <= w_cost_beat;
      r_update <= w_update_beat;
      r_done   <= (r_state == DONE) && !r_done;
      if (w_beat) begin
        r_layer_index <= w_pos_layer;
        r_row_index   <= w_pos_row;
      end
      if (w_accept) r_diff_start <= diff_in;
    end
  end

  assign w_layer_index = r_layer_index;
  assign w_row_index   = r_row_index;
  assign backprop_cost = r_cost;
  assign is_cost_layer = r_cost;
  assign is_update     = r_update;
  assign diff_start    = r_diff_start;
  assign done          = r_done;
  assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_backprop_sequencer.sv
// Directed bench for backprop_sequencer: per-edge vector tables plus a hand-written
// asynchronous reset sequence.
module tb_backprop_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, hold, abort;
  logic [47:0] diff_in;
  logic [31:0] w_layer_index, w_row_index;
  logic        backprop_cost, is_cost_layer, is_update, busy, done;
  logic [47:0] diff_start;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [47:0] D1 = 48'h0003_0002_0001;
  localparam logic [47:0] D2 = 48'h0C0C_0B0B_0A0A;
  localparam logic [47:0] D3 = 48'h1234_5678_9ABC;
  localparam logic [47:0] DX = 48'hFFFF_FFFF_FFFF;

  backprop_sequencer #(.SIZE(3), .DATA_SIZE(16), .LAYER_COUNT(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .hold          (hold),
    .abort         (abort),
    .diff_in       (diff_in),
    .w_layer_index (w_layer_index),
    .w_row_index   (w_row_index),
    .backprop_cost (backprop_cost),
    .is_cost_layer (is_cost_layer),
    .is_update     (is_update),
    .diff_start    (diff_start),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start, hold, abort;
    logic [47:0] din;
    logic [31:0] lay, row;
    logic        cost, upd, done, busy;
    logic [47:0] dst;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic s, input logic h, input logic a, input logic [47:0] din,
                     input int lay, input int row, input logic c, input logic u,
                     input logic d, input logic b, input logic [47:0] dst);
    vec_t v;
    v.start = s; v.hold = h; v.abort = a; v.din = din;
    v.lay = lay; v.row = row; v.cost = c; v.upd = u; v.done = d; v.busy = b; v.dst = dst;
    tbl.push_back(v);
  endtask

  // Uninterrupted run: start edge, 3 cost beats, 9 update beats, done, idle.
  task automatic add_run(input logic [47:0] d, input int pl, input int pr);
    add(1, 0, 0, d, pl, pr, 0, 0, 0, 1, d);
    for (int r = 0; r < 3; r++) add(0, 0, 0, '0, 2, r, 1, 0, 0, 1, d);
    for (int l = 2; l >= 0; l--)
      for (int r = 0; r < 3; r++) add(0, 0, 0, '0, l, r, 0, 1, 0, 1, d);
    add(0, 0, 0, '0, 0, 2, 0, 0, 1, 1, d);
    add(0, 0, 0, '0, 0, 2, 0, 0, 0, 0, d);
  endtask

  function automatic logic [127:0] observed();
    return {11'd0, w_layer_index, w_row_index, backprop_cost, is_cost_layer,
            is_update, done, busy, diff_start};
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      start = tbl[i].start; hold = tbl[i].hold; abort = tbl[i].abort; diff_in = tbl[i].din;
      @(posedge clk);
      #1;
      chk($sformatf("%s_vec%0d", tag, i), observed(),
          {11'd0, tbl[i].lay, tbl[i].row, tbl[i].cost, tbl[i].cost, tbl[i].upd,
           tbl[i].done, tbl[i].busy, tbl[i].dst});
    end
    tbl.delete();
    @(negedge clk);
    start = 1'b0; hold = 1'b0; abort = 1'b0; diff_in = '0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; hold = 1'b0; abort = 1'b0; diff_in = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", observed(), 128'd0);
    rst_n = 1'b1;

    // basic run, then back-to-back run with hold and ignored start
    add_run(D1, 0, 0);
    add(1, 0, 0, D1, 0, 2, 0, 0, 0, 1, D1);
    for (int r = 0; r < 3; r++) add(0, 0, 0, '0, 2, r, 1, 0, 0, 1, D1);
    add(0, 0, 0, '0, 2, 0, 0, 1, 0, 1, D1);
    add(0, 1, 0, '0, 2, 0, 0, 0, 0, 1, D1);
    add(1, 1, 0, DX, 2, 0, 0, 0, 0, 1, D1);
    add(0, 0, 0, '0, 2, 1, 0, 1, 0, 1, D1);
    add(0, 0, 0, '0, 2, 2, 0, 1, 0, 1, D1);
    for (int l = 1; l >= 0; l--)
      for (int r = 0; r < 3; r++) add(0, 0, 0, '0, l, r, 0, 1, 0, 1, D1);
    add(0, 0, 0, '0, 0, 2, 0, 0, 1, 1, D1);
    add(0, 0, 0, '0, 0, 2, 0, 0, 0, 0, D1);

    // abort mid-BACKPROP, restart, run into BACKPROP again
    add(1, 0, 0, D3, 0, 2, 0, 0, 0, 1, D3);
    for (int r = 0; r < 3; r++) add(0, 0, 0, '0, 2, r, 1, 0, 0, 1, D3);
    for (int r = 0; r < 3; r++) add(0, 0, 0, '0, 2, r, 0, 1, 0, 1, D3);
    add(0, 0, 0, '0, 1, 0, 0, 1, 0, 1, D3);
    add(0, 1, 1, '0, 0, 0, 0, 0, 0, 0, '0);
    add(0, 0, 0, '0, 0, 0, 0, 0, 0, 0, '0);
    add(1, 0, 0, D1, 0, 0, 0, 0, 0, 1, D1);
    for (int r = 0; r < 3; r++) add(0, 0, 0, '0, 2, r, 1, 0, 0, 1, D1);
    for (int r = 0; r < 2; r++) add(0, 0, 0, '0, 2, r, 0, 1, 0, 1, D1);
    run_table("seqA");

    // asynchronous reset in the high phase while in BACKPROP
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_immediate", observed(), 128'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("async_reset_held%0d", i), observed(), 128'd0);
    end
    rst_n = 1'b1;

    add_run(D2, 0, 0);
    run_table("seqB");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/backprop_sequencer.md
# backprop_sequencer

Issue-side controller for the backprop pipeline. On a start request it captures the output-error vector. It then emits the ordered stream of (layer, row) control beats that feeds the first backprop pipeline register stage: first the cost-layer beats, then weight-update beats from the last layer down to layer 0. It supports stall bubbles, abort, and a one-cycle completion pulse.

## Interface
- `size`, 3, rows per layer; also the element count of the diff vector.
- `data_size`, 16, bits per diff element.
- `layer_count`, 3, number of weight layers, indexed 0..layer_count-1.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `start`  input  1  begin a sequence; sampled only in IDLE.
- `hold`  input  1  stall; freezes position and inserts a bubble.
- `abort`  input  1  synchronous cancel, valid in any state.
- `diff_in`  input  size*data_size  output-error vector, captured on accepted start.
- `w_layer_index`  output  32  layer of the current beat.
- `w_row_index`  output  32  row of the current beat.
- `backprop_cost`  output  1  beat is a cost-layer beat.
- `is_cost_layer`  output  1  same qualifier as backprop_cost.
- `is_update`  output  1  beat is a weight-update beat.
- `diff_start`  output  size*data_size  captured diff_in, held for the whole sequence.
- `busy`  output  1  state != IDLE.
- `done`  output  1  one-cycle completion pulse.

## Operation
- States: IDLE, COST, BACKPROP, DONE. The position counter (layer L, row r) is internal.
- IDLE
  - start=1 → COST with L=layer_count-1, r=0, and diff_start<=diff_in.
  - Otherwise stay in IDLE.
- COST
  - Each edge with hold=0 registers one beat: layer=L, row=r, backprop_cost=1, is_cost_layer=1, is_update=0. r then advances.
  - After the beat with r=size-1 → BACKPROP, with L=layer_count-1 and r=0.
- BACKPROP
  - Each edge with hold=0 registers one beat: layer=L, row=r, is_update=1, cost qualifiers 0.
  - r wraps from size-1 to 0 and L decrements on the wrap.
  - After the beat (L=0, r=size-1) → DONE.
- DONE: done<=1 for one cycle, then → IDLE on the next edge.
- Hold, in COST or BACKPROP
  - The edge registers all qualifiers to 0. Indices keep their last value.
  - The position counter does not advance, so the same (L, r) is issued on the next non-hold edge.
  - Every position is issued exactly once with its qualifier high.
  - hold is ignored in IDLE and DONE.
- abort: at any edge, go to IDLE. Qualifiers, indices and diff_start are cleared to 0 and done stays 0. abort has priority over hold and start.
- start while busy is ignored; diff_start is unchanged.
- Index outputs are zero-extended to 32 bits. No arithmetic is performed on diff data; it is captured and held only.
- Reset: every output and internal register is 0 and the state is IDLE. Reset mid-sequence drops the sequence with no done pulse.

## Timing
- All outputs are registered, except busy, which is decoded directly from the state flop.
- Let start be accepted at edge k.
- First beat is visible after edge k+1.
- Without hold there are N = size·(layer_count+1) beats, covering edges k+1..k+N.
- done is high after edge k+N+1. busy falls after edge k+N+2.
- Each hold cycle delays everything after it by exactly one cycle.
- Back-to-back runs: start is accepted in the cycle after busy falls.

## Structure
- Shared package `backprop_pkg`:
  - state enum `bp_state_t` (IDLE, COST, BACKPROP, DONE)
  - `BP_INDEX_W` = 32
- Sub-module `backprop_position_counter`, used for both phases. It is a nested counter: row counts up and wraps, layer counts down on the row wrap. Ports: load, advance, last flag.
- The top level holds the FSM, the output registers and the diff_start capture register.

## Test plan
All scenarios use size=3, data_size=16, layer_count=3, so N=12.
- Reset: assert rst_n=0 mid-clock → all outputs 0 immediately (asynchronous), busy=0.
- Basic run: start with diff_in=48'h0003_0002_0001 at edge k →
  - edges k+1..k+3: layer 2, rows 0,1,2, backprop_cost=is_cost_layer=1;
  - edges k+4..k+12: (2,0..2), (1,0..2), (0,0..2) with is_update=1;
  - done=1 only after edge k+13;
  - diff_start=48'h0003_0002_0001 throughout.
- Hold: hold=1 for edges k+5 and k+6 → qualifiers 0 on those edges, indices stay (2,0); (2,1) issued at k+7; done after edge k+15.
- Start while busy: pulse start with diff_in=48'hFFFF_FFFF_FFFF at edge k+6 → sequence unchanged, diff_start unchanged.
- Abort: abort=1 at edge k+8 → after that edge state is IDLE, all outputs 0, no done. A new start at k+10 gives its first beat (2,0) cost after edge k+11.
- Async reset mid-BACKPROP: rst_n=0 at k+7 for 2 cycles → outputs 0, no done. A start after release runs the full 12-beat sequence.
